// File: rtl/cache_ctrl_pkg.sv
// ============================================================================
// Module   : cache_ctrl_pkg
// Purpose  : Shared state encoding and statistics width for cache_ctrl_fsm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_ctrl_pkg;

    localparam int STATS_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        FILL  = 2'd2,
        RETRY = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cache_ctrl_fill_tracker.sv
// ============================================================================
// Module   : cache_ctrl_fill_tracker
// Purpose  : MEM_LAT-deep shift register tagging each issued fill read with
//            its word index so the write lands when the memory data is valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl_fill_tracker #(
    parameter int MEM_LAT = 2,
    parameter int OFF_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [OFF_W-1:0] i_push_idx,
    output logic             o_pop,
    output logic [OFF_W-1:0] o_pop_idx
);

    logic [MEM_LAT-1:0] r_vld;
    logic [OFF_W-1:0]   r_idx [MEM_LAT];

    // Reset drops every in-flight read so stale data is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_push;
            r_idx[0] <= i_push_idx;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign o_pop     = r_vld[MEM_LAT-1];
    assign o_pop_idx = r_idx[MEM_LAT-1];

endmodule

`default_nettype wire

// File: rtl/cache_ctrl_fsm.sv
// ============================================================================
// Module   : cache_ctrl_fsm
// Purpose  : Direct-mapped cache controller: hits, dirty write-back, line
//            fill through fixed-latency memory, retry. Optional statistics
//            counters enabled by CACHE_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    parameter int OFF_W   = $clog2(WORDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Rd,
    input  logic               Wr,
    input  logic               hit,
    input  logic               valid,
    input  logic               dirty,
    input  logic               mem_stall,
    output logic               cache_en,
    output logic               cache_comp,
    output logic               cache_write,
    output logic [OFF_W-1:0]   cache_word,
    output logic               use_mem_data,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [OFF_W-1:0]   mem_word,
    output logic               mem_tag_sel,
    output logic               Done,
    output logic               Stall,
    output logic               CacheHit,
    output logic               err,
    output logic [STATS_W-1:0] hit_count,
    output logic [STATS_W-1:0] miss_count
);

    localparam int             CNT_W   = OFF_W + 1;
    localparam logic [CNT_W-1:0] c_words = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(WORDS - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_rcv;
    logic               r_op_wr;

    logic               w_req;
    logic               w_both;
    logic               w_hit;
    logic               w_issue;
    logic               w_pop;
    logic               w_ret;
    logic [OFF_W-1:0]   w_ret_idx;

    // Requests are masked while reset is held so outputs stay quiet.
    assign w_req   = rst_n & (Rd ^ Wr);
    assign w_both  = rst_n & Rd & Wr;
    assign w_hit   = hit & valid;
    assign w_issue = (r_state == FILL) && !mem_stall && (r_cnt < c_words);
    assign w_ret   = (r_state == FILL) && w_pop;

    cache_ctrl_fill_tracker #(
        .MEM_LAT (MEM_LAT),
        .OFF_W   (OFF_W)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_issue),
        .i_push_idx (r_cnt[OFF_W-1:0]),
        .o_pop      (w_pop),
        .o_pop_idx  (w_ret_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rcv   <= '0;
            r_op_wr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !w_hit) begin
                        r_op_wr <= Wr;
                        r_cnt   <= '0;
                        r_rcv   <= '0;
                        r_state <= (valid && dirty) ? WB : FILL;
                    end
                end
                WB: begin
                    if (!mem_stall) begin
                        if (r_cnt == c_last) begin
                            r_cnt   <= '0;
                            r_state <= FILL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (w_issue) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_ret) begin
                        r_rcv <= r_rcv + 1'b1;
                        if (r_rcv == c_last) begin
                            r_state <= RETRY;
                        end
                    end
                end
                RETRY: begin
                    r_cnt   <= '0;
                    r_rcv   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cache_en     = 1'b0;
        cache_comp   = 1'b0;
        cache_write  = 1'b0;
        cache_word   = '0;
        use_mem_data = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_word     = '0;
        mem_tag_sel  = 1'b0;
        Done         = 1'b0;
        Stall        = 1'b0;
        CacheHit     = 1'b0;
        err          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    cache_en    = 1'b1;
                    cache_comp  = 1'b1;
                    cache_write = Wr;
                    Done        = w_hit;
                    CacheHit    = w_hit;
                    Stall       = !w_hit;
                end else if (w_both) begin
                    err = 1'b1;
                end
            end
            WB: begin
                Stall = 1'b1;
                if (!mem_stall) begin
                    cache_en    = 1'b1;
                    cache_word  = r_cnt[OFF_W-1:0];
                    mem_wr      = 1'b1;
                    mem_word    = r_cnt[OFF_W-1:0];
                    mem_tag_sel = 1'b1;
                end
            end
            FILL: begin
                Stall = 1'b1;
                if (w_issue) begin
                    mem_rd   = 1'b1;
                    mem_word = r_cnt[OFF_W-1:0];
                end
                if (w_ret) begin
                    cache_en     = 1'b1;
                    cache_write  = 1'b1;
                    use_mem_data = 1'b1;
                    cache_word   = w_ret_idx;
                end
            end
            RETRY: begin
                cache_en    = 1'b1;
                cache_comp  = 1'b1;
                cache_write = r_op_wr;
                Done        = 1'b1;
                Stall       = 1'b1;
                err         = !hit;
            end
            default: ;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic               w_hit_evt;
    logic               w_miss_evt;
    logic [STATS_W-1:0] r_hit_count;
    logic [STATS_W-1:0] r_miss_count;

    assign w_hit_evt  = (r_state == IDLE) && w_req && w_hit;
    assign w_miss_evt = (r_state == IDLE) && w_req && !w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_evt && (r_hit_count != {STATS_W{1'b1}})) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_miss_evt && (r_miss_count != {STATS_W{1'b1}})) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl_fsm.sv
// ============================================================================
// Module   : tb_cache_ctrl_fsm
// Purpose  : Self-checking bench for cache_ctrl_fsm (vector table, directed
//            miss/reset sequences, randomized transactions vs. event model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_ctrl_fsm;

    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int OFF_W   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic Rd, Wr, hit, valid, dirty, mem_stall;
    logic cache_en, cache_comp, cache_write, use_mem_data;
    logic mem_rd, mem_wr, mem_tag_sel, Done, Stall, CacheHit, err;
    logic [OFF_W-1:0] cache_word, mem_word;
    logic [15:0] hit_count, miss_count;

    always #5 clk = ~clk;

    cache_ctrl_fsm #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .Rd(Rd), .Wr(Wr), .hit(hit), .valid(valid),
        .dirty(dirty), .mem_stall(mem_stall), .cache_en(cache_en),
        .cache_comp(cache_comp), .cache_write(cache_write),
        .cache_word(cache_word), .use_mem_data(use_mem_data), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_word(mem_word), .mem_tag_sel(mem_tag_sel),
        .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct packed {
        logic             en, comp, wr;
        logic [OFF_W-1:0] cw;
        logic             umd, mrd, mwr;
        logic [OFF_W-1:0] mw;
        logic             ts, done, stall, chit, err;
    } outs_t;

    typedef struct {
        logic  rd, wr, hit, valid, dirty;
        outs_t exp;
    } vec_t;

    outs_t act;
    assign act = {cache_en, cache_comp, cache_write, cache_word, use_mem_data,
                  mem_rd, mem_wr, mem_word, mem_tag_sel, Done, Stall, CacheHit, err};

    int checks = 0;
    int errors = 0;
    int hits_exp = 0;
    int miss_exp = 0;
    vec_t vecs[7];

    function automatic outs_t mk(bit en, bit comp, bit wr, bit done, bit chit, bit e);
        outs_t o = '0;
        o.en = en; o.comp = comp; o.wr = wr; o.done = done; o.chit = chit; o.err = e;
        return o;
    endfunction

    task automatic cmp(input string name, input outs_t e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, e, $time);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef CACHE_CTRL_STATS_EN
        chk_int({name, "_hits"}, int'(hit_count), hits_exp);
        chk_int({name, "_misses"}, int'(miss_count), miss_exp);
`else
        chk_int({name, "_hits"}, int'(hit_count), 0);
        chk_int({name, "_misses"}, int'(miss_count), 0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Miss transaction modelled as events: write-back words in order, fill
    // reads in order, and each read's write due MEM_LAT cycles after issue.
    // mode: 0 no stalls, 1 random stalls and CPU drop, 2 stall fill cycles 1-2.
    task automatic do_miss(input bit wr, input bit dty, input int mode, output int done_cyc);
        outs_t e;
        int t, nxt, issued, written, fill_t;
        int due_q[$];
        int idx_q[$];
        bit st;
        Rd = !wr; Wr = wr; dirty = dty; mem_stall = 1'b0;
        valid = dty ? 1'b1 : 1'($urandom_range(0, 1));
        hit = valid ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        e = mk(1, 1, wr, 0, 0, 0); e.stall = 1'b1;
        cmp("miss_req", e);
        miss_exp++;
        step();
        t = 1;
        hit = 1'($urandom_range(0, 1)); valid = 1'($urandom_range(0, 1));
        dirty = 1'($urandom_range(0, 1));
        if (mode == 1 && $urandom_range(0, 1) == 1) begin
            Rd = 1'b0; Wr = 1'b0;
        end
        if (dty) begin
            nxt = 0;
            while (nxt < WORDS && t < 100) begin
                st = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
                mem_stall = st;
                @(negedge clk);
                e = '0; e.stall = 1'b1;
                if (!st) begin
                    e.en = 1'b1; e.cw = OFF_W'(nxt); e.mwr = 1'b1;
                    e.mw = OFF_W'(nxt); e.ts = 1'b1;
                    nxt++;
                end
                cmp("wb", e);
                step();
                t++;
            end
        end
        issued = 0; written = 0; fill_t = 0;
        while (written < WORDS && t < 200) begin
            st = (mode == 1) ? ($urandom_range(0, 3) == 0) :
                 (mode == 2) ? (fill_t == 1 || fill_t == 2) : 1'b0;
            mem_stall = st;
            @(negedge clk);
            e = '0; e.stall = 1'b1;
            if (!st && issued < WORDS) begin
                e.mrd = 1'b1; e.mw = OFF_W'(issued);
                due_q.push_back(t + MEM_LAT);
                idx_q.push_back(issued);
                issued++;
            end
            if (due_q.size() > 0 && due_q[0] == t) begin
                e.en = 1'b1; e.wr = 1'b1; e.umd = 1'b1; e.cw = OFF_W'(idx_q[0]);
                void'(due_q.pop_front());
                void'(idx_q.pop_front());
                written++;
            end
            cmp("fill", e);
            step();
            t++;
            fill_t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL miss_timeout: got no completion expected done within 200 cycles");
        end
        mem_stall = 1'b0;
        hit = 1'($urandom_range(0, 1));
        @(negedge clk);
        e = mk(1, 1, wr, 1, 0, !hit); e.stall = 1'b1;
        cmp("retry", e);
        done_cyc = t;
        step();
        Rd = 1'b0; Wr = 1'b0; hit = 1'b0; valid = 1'b0; dirty = 1'b0;
    endtask

    initial begin : main
        int dc;
        outs_t e;
        vecs[0] = '{rd:0, wr:0, hit:0, valid:0, dirty:0, exp:mk(0,0,0,0,0,0)};
        vecs[1] = '{rd:1, wr:0, hit:1, valid:1, dirty:0, exp:mk(1,1,0,1,1,0)};
        vecs[2] = '{rd:0, wr:1, hit:1, valid:1, dirty:1, exp:mk(1,1,1,1,1,0)};
        vecs[3] = '{rd:1, wr:1, hit:1, valid:1, dirty:0, exp:mk(0,0,0,0,0,1)};
        vecs[4] = '{rd:1, wr:1, hit:0, valid:1, dirty:1, exp:mk(0,0,0,0,0,1)};
        vecs[5] = '{rd:0, wr:0, hit:1, valid:1, dirty:1, exp:mk(0,0,0,0,0,0)};
        vecs[6] = '{rd:1, wr:0, hit:1, valid:1, dirty:1, exp:mk(1,1,0,1,1,0)};

        rst_n = 1'b0; Rd = 0; Wr = 0; hit = 0; valid = 0; dirty = 0; mem_stall = 0;
        #3;
        cmp("reset_outs", '0);
        chk_stats("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmp("post_reset_idle", '0);
        step();

        foreach (vecs[i]) begin
            Rd = vecs[i].rd; Wr = vecs[i].wr; hit = vecs[i].hit;
            valid = vecs[i].valid; dirty = vecs[i].dirty;
            @(negedge clk);
            cmp($sformatf("vec%0d", i), vecs[i].exp);
            if (vecs[i].rd ^ vecs[i].wr) hits_exp++;
            step();
        end
        Rd = 0; Wr = 0;

        do_miss(1'b0, 1'b0, 0, dc);
        chk_int("clean_read_done_cycle", dc, WORDS + MEM_LAT + 1);
        @(negedge clk);
        cmp("idle_after_retry", '0);
        step();
        do_miss(1'b1, 1'b1, 0, dc);
        chk_int("dirty_write_done_cycle", dc, 2 * WORDS + MEM_LAT + 1);
        do_miss(1'b0, 1'b0, 2, dc);
        chk_int("stalled_fill_done_cycle", dc, WORDS + MEM_LAT + 3);
        chk_stats("after_directed");

        // Reset asserted in cycle 3 of a clean read miss, request held.
        Rd = 1; Wr = 0; hit = 0; valid = 1; dirty = 0;
        repeat (3) step();
        rst_n = 1'b0;
        hits_exp = 0; miss_exp = 0;
        #1;
        cmp("reset_mid_miss_immediate", '0);
        @(negedge clk);
        cmp("reset_mid_miss_held", '0);
        chk_stats("reset_mid_miss");
        step();
        rst_n = 1'b1; hit = 1;
        @(negedge clk);
        cmp("fresh_lookup_after_reset", mk(1, 1, 0, 1, 1, 0));
        hits_exp++;
        step();
        Rd = 0; hit = 0;
        for (int k = 0; k < MEM_LAT + 2; k++) begin
            @(negedge clk);
            cmp("no_stale_fill", '0);
            step();
        end

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 4);
            if (kind <= 1) begin
                bit w;
                w = 1'($urandom_range(0, 1));
                do_miss(w, 1'($urandom_range(0, 1)), 1, dc);
            end else if (kind == 2) begin
                bit w;
                w = 1'($urandom_range(0, 1));
                Rd = !w; Wr = w; hit = 1; valid = 1; dirty = 1'($urandom_range(0, 1));
                mem_stall = 1'($urandom_range(0, 1));
                @(negedge clk);
                cmp("rand_hit", mk(1, 1, w, 1, 1, 0));
                hits_exp++;
                step();
            end else if (kind == 3) begin
                Rd = 1; Wr = 1; hit = 1'($urandom_range(0, 1)); valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                cmp("rand_err", mk(0, 0, 0, 0, 0, 1));
                step();
            end else begin
                Rd = 0; Wr = 0; hit = 1'($urandom_range(0, 1)); mem_stall = 1'($urandom_range(0, 1));
                @(negedge clk);
                cmp("rand_idle", '0);
                step();
            end
            Rd = 0; Wr = 0; mem_stall = 0;
        end
        chk_stats("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
